// File: rtl/fft4_stream.sv
// Streaming 4-point complex FFT: one sample in and one natural-order bin out per clock.
// Latency: bin Xk of a frame appears on y after edge E+1+k, where E captures sample x3.
// No backpressure: the input is consumed every cycle and output is produced every cycle.
module fft4_stream (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x_real,
    input  logic [15:0] x_imag,
    output logic [15:0] y_real,
    output logic [15:0] y_imag
);

    localparam logic signed [17:0] SAT_MAX = 18'sd32767;
    localparam logic signed [17:0] SAT_MIN = -18'sd32768;

    // Clamp an 18-bit internal result into the 16-bit output range.
    function automatic logic [15:0] sat16(input logic signed [17:0] v);
        if (v > SAT_MAX) begin
            return 16'h7fff;
        end else if (v < SAT_MIN) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

    logic [1:0]  r_cnt;
    logic [15:0] r_in_re  [3];
    logic [15:0] r_in_im  [3];
    logic [15:0] r_bank_re[4];
    logic [15:0] r_bank_im[4];

    logic signed [17:0] w_x_re [4];
    logic signed [17:0] w_x_im [4];
    logic signed [17:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [17:0] w_c_re, w_c_im, w_d_re, w_d_im;
    logic signed [17:0] w_X_re [4];
    logic signed [17:0] w_X_im [4];

    // Radix-2 DIT butterflies on the buffered samples plus the live fourth sample.
    always_comb begin
        w_x_re[0] = {{2{r_in_re[0][15]}}, r_in_re[0]};
        w_x_im[0] = {{2{r_in_im[0][15]}}, r_in_im[0]};
        w_x_re[1] = {{2{r_in_re[1][15]}}, r_in_re[1]};
        w_x_im[1] = {{2{r_in_im[1][15]}}, r_in_im[1]};
        w_x_re[2] = {{2{r_in_re[2][15]}}, r_in_re[2]};
        w_x_im[2] = {{2{r_in_im[2][15]}}, r_in_im[2]};
        w_x_re[3] = {{2{x_real[15]}}, x_real};
        w_x_im[3] = {{2{x_imag[15]}}, x_imag};

        w_a_re = w_x_re[0] + w_x_re[2];
        w_a_im = w_x_im[0] + w_x_im[2];
        w_b_re = w_x_re[0] - w_x_re[2];
        w_b_im = w_x_im[0] - w_x_im[2];
        w_c_re = w_x_re[1] + w_x_re[3];
        w_c_im = w_x_im[1] + w_x_im[3];
        w_d_re = w_x_re[1] - w_x_re[3];
        w_d_im = w_x_im[1] - w_x_im[3];

        // Twiddles are 1 and -j, so the second stage is adds and swaps only.
        w_X_re[0] = w_a_re + w_c_re;
        w_X_im[0] = w_a_im + w_c_im;
        w_X_re[1] = w_b_re + w_d_im;
        w_X_im[1] = w_b_im - w_d_re;
        w_X_re[2] = w_a_re - w_c_re;
        w_X_im[2] = w_a_im - w_c_im;
        w_X_re[3] = w_b_re - w_d_im;
        w_X_im[3] = w_b_im + w_d_re;
    end

    // Frame counter, input capture, result bank load and output streaming.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= 2'd0;
            y_real <= 16'd0;
            y_imag <= 16'd0;
            for (int i = 0; i < 3; i++) begin
                r_in_re[i] <= 16'd0;
                r_in_im[i] <= 16'd0;
            end
            for (int i = 0; i < 4; i++) begin
                r_bank_re[i] <= 16'd0;
                r_bank_im[i] <= 16'd0;
            end
        end else begin
            r_cnt  <= r_cnt + 2'd1;
            // Reads the bank before this edge's load, so cnt==3 emits the previous X3.
            y_real <= r_bank_re[r_cnt];
            y_imag <= r_bank_im[r_cnt];
            case (r_cnt)
                2'd0: begin
                    r_in_re[0] <= x_real;
                    r_in_im[0] <= x_imag;
                end
                2'd1: begin
                    r_in_re[1] <= x_real;
                    r_in_im[1] <= x_imag;
                end
                2'd2: begin
                    r_in_re[2] <= x_real;
                    r_in_im[2] <= x_imag;
                end
                default: begin
                    for (int k = 0; k < 4; k++) begin
                        r_bank_re[k] <= sat16(w_X_re[k]);
                        r_bank_im[k] <= sat16(w_X_im[k]);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft4_stream.sv
// Bench for fft4_stream: drives one sample per clock and checks every output bin.
// Expected bins come from a direct-form DFT model of each frame.
// Expectations are queued as each edge is driven and popped once y has settled.
module tb_fft4_stream;

    logic        clk;
    logic        reset;
    logic [15:0] x_real;
    logic [15:0] x_imag;
    logic [15:0] y_real;
    logic [15:0] y_imag;

    fft4_stream u_dut (
        .clk    (clk),
        .reset  (reset),
        .x_real (x_real),
        .x_imag (x_imag),
        .y_real (y_real),
        .y_imag (y_imag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_y;

    int          m_cnt = 0;
    int          m_buf_re[3];
    int          m_buf_im[3];
    logic [31:0] m_bank[4];

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got re=%0d im=%0d, want re=%0d im=%0d", tag,
                     $signed(obs[31:16]), $signed(obs[15:0]),
                     $signed(exp[31:16]), $signed(exp[15:0]));
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [31:0] pack(input int re, input int im);
        logic [15:0] r16;
        logic [15:0] i16;
        r16 = 16'(sat(re));
        i16 = 16'(sat(im));
        return {r16, i16};
    endfunction

    // Direct DFT: X_k = sum x_n * (-j)^(n*k).
    task automatic model_frame(input int xr[4], input int xi[4]);
        for (int k = 0; k < 4; k++) begin
            int sr;
            int si;
            sr = 0;
            si = 0;
            for (int n = 0; n < 4; n++) begin
                case ((n * k) % 4)
                    0: begin sr += xr[n]; si += xi[n]; end
                    1: begin sr += xi[n]; si -= xr[n]; end
                    2: begin sr -= xr[n]; si -= xi[n]; end
                    default: begin sr -= xi[n]; si += xr[n]; end
                endcase
            end
            m_bank[k] = pack(sr, si);
        end
    endtask

    // Drive one clock of stimulus, predict the output of that edge, then check it.
    task automatic step(input string tag, input int xr, input int xi, input bit rst);
        logic [31:0] e;
        int fr[4];
        int fi[4];
        @(negedge clk);
        reset  = rst;
        x_real = 16'(xr);
        x_imag = 16'(xi);
        @(posedge clk);
        if (rst) begin
            m_cnt = 0;
            for (int i = 0; i < 3; i++) begin
                m_buf_re[i] = 0;
                m_buf_im[i] = 0;
            end
            for (int i = 0; i < 4; i++) m_bank[i] = 32'd0;
            exp_q.push_back(32'd0);
        end else begin
            exp_q.push_back(m_bank[m_cnt]);
            if (m_cnt < 3) begin
                m_buf_re[m_cnt] = xr;
                m_buf_im[m_cnt] = xi;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    fr[i] = m_buf_re[i];
                    fi[i] = m_buf_im[i];
                end
                fr[3] = xr;
                fi[3] = xi;
                model_frame(fr, fi);
            end
            m_cnt = (m_cnt + 1) % 4;
        end
        #1;
        e = exp_q.pop_front();
        last_y = {y_real, y_imag};
        check(tag, last_y, e);
    endtask

    task automatic frame(input string tag, input int r0, i0, r1, i1, r2, i2, r3, i3);
        step(tag, r0, i0, 1'b0);
        step(tag, r1, i1, 1'b0);
        step(tag, r2, i2, 1'b0);
        step(tag, r3, i3, 1'b0);
    endtask

    initial begin
        reset  = 1'b1;
        x_real = 16'd0;
        x_imag = 16'd0;

        step("reset", 0, 0, 1'b1);
        step("reset", 0, 0, 1'b1);
        check("reset_y_zero", last_y, 32'd0);

        // Ramp frame; its bins stream out while the impulse frame is driven.
        frame("ramp_prefill", 0, 0, 1, 0, 2, 0, 3, 0);
        step("ramp", 1, 0, 1'b0);
        check("ramp_X0_lit", last_y, pack(6, 0));
        step("ramp", 0, 0, 1'b0);
        check("ramp_X1_lit", last_y, pack(-2, 2));
        step("ramp", 0, 0, 1'b0);
        check("ramp_X2_lit", last_y, pack(-2, 0));
        step("ramp", 0, 0, 1'b0);
        check("ramp_X3_lit", last_y, pack(-2, -2));

        frame("dc", 100, -50, 100, -50, 100, -50, 100, -50);
        frame("imag", 0, 1, 0, 2, 0, 3, 0, 4);
        frame("sat", 32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768);
        step("sat_out", -32768, 32767, 1'b0);
        check("sat_X0_lit", last_y, {16'h7fff, 16'h8000});
        step("sat_out", -32768, 32767, 1'b0);
        step("sat_out", -32768, 32767, 1'b0);
        step("sat_out", -32768, 32767, 1'b0);
        frame("b2b_a", 1, 0, 2, 0, 3, 0, 4, 0);
        frame("b2b_b", 4, 0, 3, 0, 2, 0, 1, 0);
        frame("b2b_out", 0, 0, 0, 0, 0, 0, 0, 0);

        // Partial frame interrupted by reset, then a fresh aligned frame.
        step("partial", 7, 7, 1'b0);
        step("partial", 9, -9, 1'b0);
        step("mid_reset", 0, 0, 1'b1);
        check("mid_reset_y_zero", last_y, 32'd0);
        frame("resync", 5, -3, -7, 2, 11, 0, -1, 8);
        frame("resync_out", 0, 0, 0, 0, 0, 0, 0, 0);

        // Random frames including full-scale values.
        for (int f = 0; f < 24; f++) begin
            for (int s = 0; s < 4; s++) begin
                int r;
                int i;
                r = $signed(16'($urandom));
                i = $signed(16'($urandom));
                if (f % 6 == 5) begin
                    r = (s % 2 == 0) ? 32767 : -32768;
                    i = (s < 2) ? -32768 : 32767;
                end
                step("random", r, i, 1'b0);
            end
        end
        frame("flush", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
